sdram_req_queue: RTL and testbench
==================================

// Module: sdram_req_queue
// PURPOSE
//  Buffered client front end for the SDRAM controller. Sits directly upstream of the controller's
//  request port (manager side of sdram_ctrl_if). Queues client read/write requests in a FIFO and
//  presents them in order, holding each until the controller accepts it. Limits in-flight reads and
//  returns read responses to the client in order.
// PARAMETERS
//  ADDR_WIDTH  32           request address width
//  DATA_WIDTH  32           data width
//  WORD_LEN    DATA_WIDTH/8 byte-enable width
//  DEPTH       8            request FIFO entries; power of 2, >=2
//  MAX_RD      4            max reads in flight at the controller; 1..255
// PORTS
//  clk         in   1           sole clock; everything is posedge clk
//  rst_n       in   1           asynchronous, active-low reset
//  req_valid   in   1           client request present
//  req_ready   out  1           queue can take a request (= !full)
//  req_we      in   WORD_LEN    byte write enables; all-zero means read
//  req_addr    in   ADDR_WIDTH  request address
//  req_wdata   in   DATA_WIDTH  write data; ignored for reads
//  resp_valid  out  1           one-cycle read-response strobe
//  resp_data   out  DATA_WIDTH  read data; 0 when resp_error=1 without data
//  resp_error  out  1           response carries a controller error
//  ctrl_wr     out  WORD_LEN    controller write byte-enables
//  ctrl_rd     out  1           controller read request
//  ctrl_addr   out  ADDR_WIDTH  controller address
//  ctrl_wdata  out  DATA_WIDTH  controller write data
//  ctrl_rdy    in   1           controller accepts the request this cycle
//  ctrl_valid  in   1           controller read data valid
//  ctrl_error  in   1           controller error strobe
//  ctrl_rdata  in   DATA_WIDTH  controller read data
//  rd_pending  out  8           reads issued but not yet completed
//  stray_resp  out  1           sticky: ctrl_valid/ctrl_error seen with rd_pending==0
// BEHAVIOUR
//  Reset: FIFO empty, rd_pending=0, req_ready=1, all ctrl_*/resp_* outputs=0, stray_resp=0.
//  Push: req_valid&req_ready writes {req_we,req_addr,req_wdata}. No push when full and no
//    pop-to-push bypass. An entry pushed at cycle N is visible on ctrl_* at N+1 at the earliest.
//  Issue: the head is eligible when FIFO is non-empty, and for reads also rd_pending<MAX_RD.
//    When eligible: ctrl_wr=head.we; ctrl_rd=(head.we==0); ctrl_addr and ctrl_wdata come from the head.
//    When not eligible: ctrl_wr=0, ctrl_rd=0, ctrl_addr and ctrl_wdata hold their last value.
//    ctrl_* outputs are stable until accepted. Accept = ctrl_rdy & (ctrl_rd | |ctrl_wr); on accept, pop.
//    A blocked read head also blocks later writes (strict order).
//  Pending count: +1 on an accepted read; -1 on completion = (ctrl_valid|ctrl_error) & rd_pending!=0.
//    Both in the same cycle leave the count unchanged. The count saturates, never wraps.
//  Response: registered, one cycle after completion.
//    resp_valid=1; resp_data=ctrl_valid ? ctrl_rdata : 0; resp_error=ctrl_error.
//    resp_valid is low in all other cycles. The client has no backpressure.
//  Completion with rd_pending==0: no response, set stray_resp. Only reset clears stray_resp.
//  Full/empty: full when count==DEPTH. Pointers are log2(DEPTH)+1 bits and wrap naturally.
//  Reset mid-operation: queued requests are discarded and the pending count is lost. Late controller
//    responses after reset are reported as stray. The client must reissue.
//  FSM: none beyond the FIFO. Eligibility is combinational from head and rd_pending.
// STRUCTURE
//  sdram_pkg: typedef struct packed {we, addr, wdata} sdram_req_t (parameterised widths via
//    localparams) and the RD_CNT_W=8 constant.
//  One sub-module: sdram_sync_fifo #(WIDTH,DEPTH). Synchronous FIFO, async active-low reset.
//    It exposes a head output, full, empty and count.
//  Top contains pending counter, eligibility logic, response register.
// TESTING
//  1. Write A=0x10 we=0xF D=0xDEADBEEF, ctrl_rdy=1 -> ctrl_wr=0xF, addr 0x10 one cycle after push; resp_valid never set.
//  2. Read 0x20, ctrl_rdy low 3 cycles -> ctrl_rd/addr held 3 cycles, popped on 4th; ctrl_valid data 0x1234 -> resp_data=0x1234 next cycle, rd_pending 1->0.
//  3. Push 9 reads with DEPTH=8 and ctrl_rdy=0 -> req_ready low after 8; 9th held until a pop.
//  4. MAX_RD=4, 6 reads, ctrl_rdy=1, no ctrl_valid -> exactly 4 accepted, ctrl_rd low, rd_pending=4; one ctrl_valid -> 5th issues next cycle.
//  5. Accept a read and get ctrl_valid in the same cycle with rd_pending=1 -> rd_pending stays 1, one resp_valid.
//  6. ctrl_error alone -> resp_error=1, resp_data=0. rst_n pulse with 3 reads pending, then ctrl_valid -> no resp, stray_resp=1.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared request layout and pending-read counter width for the SDRAM request queue
package sdram_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WE_W = DATA_W / 8;
  localparam int RD_CNT_W = 8;
  typedef struct packed {
    logic [WE_W-1:0] we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sdram_req_t;
endpackage

// File: rtl/sdram_sync_fifo.sv
// sdram_sync_fifo: synchronous FIFO; ports push/din in, pop in, head/full/empty/count out
module sdram_sync_fifo
  import sdram_pkg::*;
#(
  parameter int WIDTH = $bits(sdram_req_t),
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = wr_ptr == rd_ptr;
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/sdram_req_queue.sv
// sdram_req_queue: buffered client front end; queues requests, issues in order, limits reads in flight, returns responses
module sdram_req_queue
  import sdram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_LEN = DATA_WIDTH / 8,
  parameter int DEPTH = 8,
  parameter int MAX_RD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WORD_LEN-1:0]   req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_error,
  output logic [WORD_LEN-1:0]   ctrl_wr,
  output logic                  ctrl_rd,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic [DATA_WIDTH-1:0] ctrl_wdata,
  input  logic                  ctrl_rdy,
  input  logic                  ctrl_valid,
  input  logic                  ctrl_error,
  input  logic [DATA_WIDTH-1:0] ctrl_rdata,
  output logic [RD_CNT_W-1:0]   rd_pending,
  output logic                  stray_resp
);
  localparam int REQ_W = WORD_LEN + ADDR_WIDTH + DATA_WIDTH;
  logic [REQ_W-1:0] head;
  logic full, empty, elig, head_rd, accept, comp, inc;
  logic [$clog2(DEPTH):0] count;
  logic [WORD_LEN-1:0] h_we;
  logic [ADDR_WIDTH-1:0] h_addr, last_addr;
  logic [DATA_WIDTH-1:0] h_wdata, last_wdata;
  sdram_sync_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(req_valid & ~full), .din({req_we, req_addr, req_wdata}),
    .pop(accept), .head(head), .full(full), .empty(empty), .count(count)
  );
  assign req_ready = count != ($clog2(DEPTH)+1)'(DEPTH);
  assign h_we = head[REQ_W-1 -: WORD_LEN];
  assign h_addr = head[DATA_WIDTH +: ADDR_WIDTH];
  assign h_wdata = head[DATA_WIDTH-1:0];
  assign head_rd = h_we == '0;
  // a read head at the in-flight limit stalls everything behind it
  assign elig = !empty && (!head_rd || rd_pending < RD_CNT_W'(MAX_RD));
  assign ctrl_wr = elig ? h_we : '0;
  assign ctrl_rd = elig & head_rd;
  assign ctrl_addr = elig ? h_addr : last_addr;
  assign ctrl_wdata = elig ? h_wdata : last_wdata;
  assign accept = ctrl_rdy & (ctrl_rd | (|ctrl_wr));
  assign inc = accept & ctrl_rd;
  assign comp = (ctrl_valid | ctrl_error) && rd_pending != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_pending <= '0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_error <= 1'b0;
      stray_resp <= 1'b0;
      last_addr <= '0;
      last_wdata <= '0;
    end else begin
      if (inc && !comp && rd_pending != '1) rd_pending <= rd_pending + 1'b1;
      else if (comp && !inc) rd_pending <= rd_pending - 1'b1;
      resp_valid <= comp;
      resp_data <= (comp && ctrl_valid) ? ctrl_rdata : '0;
      resp_error <= comp && ctrl_error;
      if ((ctrl_valid || ctrl_error) && rd_pending == '0) stray_resp <= 1'b1;
      if (elig) begin
        last_addr <= h_addr;
        last_wdata <= h_wdata;
      end
    end
endmodule

// File: tb/tb_sdram_req_queue.sv
// tb_sdram_req_queue: directed scenarios plus random traffic checked against a queue-based model
module tb_sdram_req_queue;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready;
  logic [3:0] req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_error;
  logic [31:0] resp_data;
  logic [3:0] ctrl_wr;
  logic ctrl_rd;
  logic [31:0] ctrl_addr, ctrl_wdata;
  logic ctrl_rdy = 0, ctrl_valid = 0, ctrl_error = 0;
  logic [31:0] ctrl_rdata = 0;
  logic [7:0] rd_pending;
  logic stray_resp;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  sdram_req_queue dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_rdy(ctrl_rdy), .ctrl_valid(ctrl_valid), .ctrl_error(ctrl_error), .ctrl_rdata(ctrl_rdata),
    .rd_pending(rd_pending), .stray_resp(stray_resp)
  );
  typedef struct {logic [3:0] we; logic [31:0] a; logic [31:0] d;} req_t;
  req_t q[$];
  int pend = 0;
  bit m_stray = 0, m_rv = 0, m_re = 0;
  logic [31:0] m_rd = 0, m_la = 0, m_lw = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
  endtask
  function automatic bit m_elig();
    return q.size() > 0 && (q[0].we != 0 || pend < 4);
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      pend = 0; m_stray = 0; m_rv = 0; m_re = 0; m_rd = 0; m_la = 0; m_lw = 0;
    end else begin
      automatic bit el = m_elig();
      automatic bit is_rd = el && q[0].we == 0;
      automatic bit acc = el && ctrl_rdy;
      automatic bit full = q.size() == 8;
      automatic bit done = (ctrl_valid || ctrl_error) && pend > 0;
      if ((ctrl_valid || ctrl_error) && pend == 0) m_stray = 1;
      m_rv = done;
      m_re = done && ctrl_error;
      m_rd = (done && ctrl_valid) ? ctrl_rdata : 0;
      if (el) begin m_la = q[0].a; m_lw = q[0].d; end
      pend += (acc && is_rd ? 1 : 0) - (done ? 1 : 0);
      if (acc) void'(q.pop_front());
      if (req_valid && !full) q.push_back('{req_we, req_addr, req_wdata});
    end
  always @(negedge clk) begin
    automatic bit el = m_elig();
    chk("req_ready", req_ready, q.size() < 8);
    chk("ctrl_rd", ctrl_rd, el && q[0].we == 0);
    chk("ctrl_wr", ctrl_wr, el ? q[0].we : 4'h0);
    chk("ctrl_addr", ctrl_addr, el ? q[0].a : m_la);
    chk("ctrl_wdata", ctrl_wdata, el ? q[0].d : m_lw);
    chk("rd_pending", rd_pending, pend);
    chk("resp_valid", resp_valid, m_rv);
    chk("resp_data", resp_data, m_rd);
    chk("resp_error", resp_error, m_re);
    chk("stray_resp", stray_resp, m_stray);
  end
  task automatic step(int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic rst_pulse();
    rst_n = 0; #2 rst_n = 1;
  endtask
  task automatic put(logic v, logic [3:0] we, logic [31:0] a, logic [31:0] d);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
  endtask
  initial begin
    step(2);
    rst_n = 1;
    chk("rst_ready", req_ready, 1);
    chk("rst_pending", rd_pending, 0);
    put(1, 4'hF, 32'h10, 32'hDEADBEEF); ctrl_rdy = 1;
    step();
    put(0, 0, 0, 0);
    chk("t1_wr", ctrl_wr, 4'hF);
    chk("t1_addr", ctrl_addr, 32'h10);
    chk("t1_wdata", ctrl_wdata, 32'hDEADBEEF);
    step();
    chk("t1_wr_done", ctrl_wr, 0);
    chk("t1_resp", resp_valid, 0);
    ctrl_rdy = 0; put(1, 0, 32'h20, 0);
    step();
    put(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_rd_held", ctrl_rd, 1);
      chk("t2_addr_held", ctrl_addr, 32'h20);
      if (i < 2) step();
    end
    ctrl_rdy = 1;
    step();
    ctrl_rdy = 0;
    chk("t2_popped", ctrl_rd, 0);
    chk("t2_pend1", rd_pending, 1);
    ctrl_valid = 1; ctrl_rdata = 32'h1234;
    step();
    ctrl_valid = 0;
    chk("t2_resp", resp_valid, 1);
    chk("t2_data", resp_data, 32'h1234);
    chk("t2_pend0", rd_pending, 0);
    rst_pulse();
    for (int i = 0; i < 8; i++) begin put(1, 0, 32'h100 + i, 0); step(); end
    chk("t3_full", req_ready, 0);
    put(1, 0, 32'h99, 0);
    step(2);
    chk("t3_still_full", req_ready, 0);
    ctrl_rdy = 1;
    step();
    ctrl_rdy = 0;
    chk("t3_room", req_ready, 1);
    step();
    put(0, 0, 0, 0);
    chk("t3_9th_in", req_ready, 0);
    rst_pulse();
    ctrl_rdy = 1;
    for (int i = 0; i < 6; i++) begin put(1, 0, 32'h200 + i, 0); step(); end
    put(0, 0, 0, 0);
    step(8);
    chk("t4_pend4", rd_pending, 4);
    chk("t4_blocked", ctrl_rd, 0);
    ctrl_valid = 1; ctrl_rdata = 32'hA5;
    step();
    ctrl_valid = 0;
    chk("t4_pend3", rd_pending, 3);
    chk("t4_5th", ctrl_rd, 1);
    chk("t4_5th_addr", ctrl_addr, 32'h204);
    step();
    chk("t4_pend4b", rd_pending, 4);
    rst_pulse();
    ctrl_rdy = 1;
    put(1, 0, 32'h300, 0);
    step();
    put(1, 0, 32'h304, 0);
    step();
    put(0, 0, 0, 0);
    chk("t5_pend1", rd_pending, 1);
    chk("t5_b_presented", ctrl_rd, 1);
    ctrl_valid = 1; ctrl_rdata = 32'h55;
    step();
    ctrl_valid = 0;
    chk("t5_pend_same", rd_pending, 1);
    chk("t5_resp", resp_valid, 1);
    chk("t5_data", resp_data, 32'h55);
    step();
    chk("t5_one_resp", resp_valid, 0);
    ctrl_error = 1; ctrl_rdata = 32'hFFFF;
    step();
    ctrl_error = 0;
    chk("t6_resp", resp_valid, 1);
    chk("t6_err", resp_error, 1);
    chk("t6_data0", resp_data, 0);
    chk("t6_pend0", rd_pending, 0);
    for (int i = 0; i < 3; i++) begin put(1, 0, 32'h400 + i, 0); step(); end
    put(0, 0, 0, 0);
    step(2);
    chk("t6_pend3", rd_pending, 3);
    rst_pulse();
    chk("t6_rst_pend", rd_pending, 0);
    chk("t6_no_stray", stray_resp, 0);
    ctrl_valid = 1;
    step();
    ctrl_valid = 0;
    chk("t6_no_resp", resp_valid, 0);
    chk("t6_stray", stray_resp, 1);
    rst_pulse();
    for (int i = 0; i < 3000; i++) begin
      automatic int r = $urandom_range(0, 99);
      put($urandom_range(0, 2) != 0, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom), $urandom, $urandom);
      ctrl_rdy = $urandom_range(0, 2) != 0;
      ctrl_valid = pend > 0 ? r < 35 : r < 1;
      ctrl_error = pend > 0 ? (r > 90) : 0;
      ctrl_rdata = $urandom;
      if (i == 1500) rst_pulse();
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
